codel_drop_ctrl: RTL and testbench
==================================

// Module: codel_drop_ctrl
// PURPOSE
//  CoDel drop-state controller that sits directly after the per-packet dodeque sojourn check.
//  Takes the per-packet okay_to_drop verdict and runs the CoDel DROPPING state machine:
//  drop count, next-drop schedule and the interval/sqrt(count) control law.
//  Issues one registered drop/forward verdict per dequeued packet to the queue manager.
// PARAMETERS
//  COUNT_W    16   drop-count width; count saturates at 2^COUNT_W-1
//  LUT_DEPTH  64   inv-sqrt table entries; count >= LUT_DEPTH uses the last entry
//  REENTER_K  16   re-entry window = REENTER_K*interval (REENTER_K must be a power of 2)
// PORTS
//  clk                  in   1        clock
//  reset                in   1        asynchronous, active-low reset (asserted when 0)
//  i__deq_valid         in   1        a dequeue attempt occurs this cycle
//  i__packet_null       in   1        the dequeue attempt found an empty queue (qualified by deq_valid)
//  i__okay_to_drop      in   1        sojourn-above-target verdict for this packet
//  i__time_counter      in   TimeCtr  current time
//  i__interval          in   TimeCtr  CoDel interval; held stable while traffic flows
//  o__verdict_valid     out  1        verdict for the previous cycle's dequeue
//  o__drop              out  1        1 = drop the packet, 0 = forward it (qualified by verdict_valid)
//  o__dropping          out  1        FSM is in the DROPPING state
//  o__count             out  COUNT_W  current drop count
//  o__drop_next         out  TimeCtr  scheduled next-drop time
// BEHAVIOUR
//  Reset: every output is 0, FSM is IDLE, count=0, drop_next=0, last_count=0. Reset is async assert, sync deassert.
//  Latency: the verdict is registered one cycle after i__deq_valid. Back-to-back dequeues every cycle
//   are allowed, and the state update for each dequeue lands on that same edge.
//  No dequeue (deq_valid=0): state holds and verdict_valid=0 next cycle.
//  Empty dequeue (deq_valid=1, packet_null=1): FSM goes to IDLE, verdict_valid=1, drop=0, count is kept.
//  Time compares are wrap-safe: "a>=b" means the signed TIME_W value (a-b) is >= 0.
//  Control law: CL(base,c) = base + ((interval * INV_SQRT[min(c,LUT_DEPTH)-1]) >> 16).
//   INV_SQRT is unsigned Q0.16, entry k = floor(65535/sqrt(k+1)).
//   The product is 2*TIME_W wide and is truncated to TIME_W after the shift.
//  IDLE, packet with ok=0: forward and stay in IDLE.
//  IDLE, packet with ok=1: drop and go to DROPPING.
//   - If count>2 and (now-drop_next) < REENTER_K*interval (signed, wrap-safe): new count = count-last_count.
//     That value is floored at 1.
//   - Otherwise: new count = 1.
//   - In both cases last_count = new count and drop_next = CL(now, new count).
//  DROPPING, packet with ok=0: forward and go to IDLE.
//  DROPPING, packet with ok=1 and now>=drop_next: drop, count = sat(count+1), drop_next = CL(drop_next, count+1).
//   last_count is unchanged.
//  DROPPING, packet with ok=1 and now<drop_next: forward and stay in DROPPING.
//  At most one drop per dequeue; the queue manager re-dequeues after a drop.
//  Count saturation: at 2^COUNT_W-1 the count holds, and the control law uses the last LUT entry.
//  Reset mid-operation: everything returns to reset values at once, and any pending verdict is discarded.
// STRUCTURE
//  CodelPkg: TimeCtr, the COUNT_W default, the INV_SQRT_FRAC=16 constant and the FSM state enum (IDLE, DROPPING).
//  Sub-module codel_inv_sqrt_lut: combinational ROM, index -> 16b fraction.
//   The ROM is generated at elaboration or from a localparam table.
//  Top level: FSM register, count, last_count, drop_next, control-law multiplier, verdict output register.
// TESTING
//  (interval=100; INV_SQRT[0]=65535, [1]=46340, [3]=32767)
//  1. Reset while DROPPING with count=5 -> next cycle dropping=0, count=0, drop_next=0, verdict_valid=0.
//  2. IDLE, t=1000, ok=1 -> verdict drop=1, dropping=1, count=1, drop_next=1099.
//  3. Continue from 2: t=1050, ok=1 -> drop=0. Then t=1099, ok=1 -> drop=1, count=2, drop_next=1099+70=1169.
//  4. While DROPPING, ok=0 at t=1120 -> drop=0, dropping=0, count stays 2.
//     Then re-entry at t=1200 (count=2, not >2) -> count=1.
//  5. Wrap: drop_next=0xFFFF_FFF0, now=0x0000_0010, ok=1 in DROPPING -> drop=1 (treated as past due).
//  6. Empty dequeue while DROPPING -> dropping=0, drop=0. A cycle with deq_valid=0 -> verdict_valid=0.

Source files
------------

// File: rtl/codel_drop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codel_drop_ctrl_pkg
// Description : Shared types and constants for the CoDel drop-state controller.
// Revision    : 1.0 - initial release
// ============================================================================
package codel_drop_ctrl_pkg;
    localparam int TIME_W          = 32;
    localparam int COUNT_W_DEFAULT = 16;
    localparam int INV_SQRT_FRAC   = 16;

    typedef logic [TIME_W-1:0] TimeCtr;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DROPPING = 1'b1
    } state_t;
endpackage
`default_nettype wire

// File: rtl/codel_inv_sqrt_lut.sv
`default_nettype none
// ============================================================================
// Module      : codel_inv_sqrt_lut
// Description : Combinational ROM, entry k = floor((2^FRAC-1)/sqrt(k+1)).
// Revision    : 1.0 - initial release
// ============================================================================
module codel_inv_sqrt_lut
    import codel_drop_ctrl_pkg::*;
#(
    parameter int LUT_DEPTH = 64,
    parameter int IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic [IDX_W-1:0]         i_idx,
    output logic [INV_SQRT_FRAC-1:0] o_frac
);

    // Exact integer evaluation: largest v with v*v*n <= (2^FRAC-1)^2.
    function automatic logic [INV_SQRT_FRAC-1:0] f_inv_sqrt(input int n);
        logic [63:0] v;
        logic [63:0] t;
        logic [63:0] lim;
        lim = ((64'd1 << INV_SQRT_FRAC) - 64'd1) * ((64'd1 << INV_SQRT_FRAC) - 64'd1);
        v   = '0;
        for (int b = INV_SQRT_FRAC - 1; b >= 0; b--) begin
            t = v | (64'd1 << b);
            if (t * t * 64'(n) <= lim) begin
                v = t;
            end
        end
        return v[INV_SQRT_FRAC-1:0];
    endfunction

    logic [INV_SQRT_FRAC-1:0] w_rom [LUT_DEPTH];

    generate
        for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
            assign w_rom[k] = f_inv_sqrt(k + 1);
        end
    endgenerate

    assign o_frac = w_rom[i_idx];

endmodule
`default_nettype wire

// File: rtl/codel_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : codel_drop_ctrl
// Description : CoDel DROPPING state machine issuing one registered verdict per dequeue.
// Revision    : 1.0 - initial release
// ============================================================================
module codel_drop_ctrl
    import codel_drop_ctrl_pkg::*;
#(
    parameter int COUNT_W   = COUNT_W_DEFAULT,
    parameter int LUT_DEPTH = 64,
    parameter int REENTER_K = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i__deq_valid,
    input  logic               i__packet_null,
    input  logic               i__okay_to_drop,
    input  TimeCtr             i__time_counter,
    input  TimeCtr             i__interval,
    output logic               o__verdict_valid,
    output logic               o__drop,
    output logic               o__dropping,
    output logic [COUNT_W-1:0] o__count,
    output TimeCtr             o__drop_next
);

    localparam int c_IDX_W   = $clog2(LUT_DEPTH);
    localparam int c_K_SHIFT = $clog2(REENTER_K);

    state_t             r_state, w_state_nxt;
    logic [COUNT_W-1:0] r_count, w_count_nxt;
    logic [COUNT_W-1:0] r_last_count, w_last_count_nxt;
    TimeCtr             r_drop_next, w_drop_next_nxt;
    logic               r_verdict_valid, r_drop, w_drop_nxt;

    logic [COUNT_W-1:0] w_count_inc, w_reenter_count, w_entry_count, w_cl_count;
    logic [c_IDX_W-1:0] w_lut_idx;
    logic [INV_SQRT_FRAC-1:0] w_frac;
    logic [2*TIME_W-1:0] w_prod;
    TimeCtr             w_cl_base, w_cl_value, w_due_diff, w_reenter_diff;
    logic               w_due, w_in_window;
    logic               w_unused_prod;

    // Wrap-safe time compares: sign bit of the modular difference.
    assign w_due_diff     = i__time_counter - r_drop_next;
    assign w_due          = ~w_due_diff[TIME_W-1];
    assign w_reenter_diff = i__time_counter - r_drop_next - (i__interval << c_K_SHIFT);
    assign w_in_window    = w_reenter_diff[TIME_W-1];

    assign w_count_inc     = (r_count == {COUNT_W{1'b1}}) ? r_count : r_count + 1'b1;
    assign w_reenter_count = (r_count > r_last_count) ? r_count - r_last_count
                                                      : {{(COUNT_W-1){1'b0}}, 1'b1};
    assign w_entry_count   = ((r_count > COUNT_W'(2)) && w_in_window) ? w_reenter_count
                                                      : {{(COUNT_W-1){1'b0}}, 1'b1};

    // One shared control-law datapath: entry uses now, in-state drops chain off drop_next.
    assign w_cl_base  = (r_state == IDLE) ? i__time_counter : r_drop_next;
    assign w_cl_count = (r_state == IDLE) ? w_entry_count   : w_count_inc;

    always_comb begin
        w_lut_idx = '0;
        if (int'(w_cl_count) >= LUT_DEPTH) begin
            w_lut_idx = c_IDX_W'(LUT_DEPTH - 1);
        end else if (w_cl_count != '0) begin
            w_lut_idx = c_IDX_W'(w_cl_count - 1'b1);
        end
    end

    codel_inv_sqrt_lut #(
        .LUT_DEPTH (LUT_DEPTH),
        .IDX_W     (c_IDX_W)
    ) u_lut (
        .i_idx  (w_lut_idx),
        .o_frac (w_frac)
    );

    assign w_prod        = {{TIME_W{1'b0}}, i__interval}
                         * {{(2*TIME_W-INV_SQRT_FRAC){1'b0}}, w_frac};
    assign w_cl_value    = w_cl_base + w_prod[INV_SQRT_FRAC +: TIME_W];
    assign w_unused_prod = ^{w_prod[INV_SQRT_FRAC-1:0], w_prod[2*TIME_W-1:INV_SQRT_FRAC+TIME_W]};

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_last_count_nxt = r_last_count;
        w_drop_next_nxt  = r_drop_next;
        w_drop_nxt       = 1'b0;
        if (i__deq_valid) begin
            if (i__packet_null) begin
                w_state_nxt = IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i__okay_to_drop) begin
                            w_drop_nxt       = 1'b1;
                            w_state_nxt      = DROPPING;
                            w_count_nxt      = w_entry_count;
                            w_last_count_nxt = w_entry_count;
                            w_drop_next_nxt  = w_cl_value;
                        end
                    end
                    DROPPING: begin
                        if (!i__okay_to_drop) begin
                            w_state_nxt = IDLE;
                        end else if (w_due) begin
                            w_drop_nxt      = 1'b1;
                            w_count_nxt     = w_count_inc;
                            w_drop_next_nxt = w_cl_value;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_last_count    <= '0;
            r_drop_next     <= '0;
            r_verdict_valid <= 1'b0;
            r_drop          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_last_count    <= w_last_count_nxt;
            r_drop_next     <= w_drop_next_nxt;
            r_verdict_valid <= i__deq_valid;
            r_drop          <= w_drop_nxt;
        end
    end

    assign o__verdict_valid = r_verdict_valid;
    assign o__drop          = r_drop;
    assign o__dropping      = (r_state == DROPPING);
    assign o__count         = r_count;
    assign o__drop_next     = r_drop_next;

endmodule
`default_nettype wire

// File: tb/tb_codel_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_codel_drop_ctrl
// Description : Directed bench for codel_drop_ctrl with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codel_drop_ctrl;

    localparam int T_W  = 32;
    localparam int C_W  = 16;
    localparam int LUTD = 64;
    localparam int K    = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           deq_valid = 1'b0;
    logic           packet_null = 1'b0;
    logic           okay_to_drop = 1'b0;
    logic [T_W-1:0] time_counter = '0;
    logic [T_W-1:0] interval = 32'd100;
    logic           verdict_valid;
    logic           drop;
    logic           dropping;
    logic [C_W-1:0] count;
    logic [T_W-1:0] drop_next;

    int n_cmp = 0;
    int n_err = 0;

    codel_drop_ctrl #(
        .COUNT_W   (C_W),
        .LUT_DEPTH (LUTD),
        .REENTER_K (K)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i__deq_valid     (deq_valid),
        .i__packet_null   (packet_null),
        .i__okay_to_drop  (okay_to_drop),
        .i__time_counter  (time_counter),
        .i__interval      (interval),
        .o__verdict_valid (verdict_valid),
        .o__drop          (drop),
        .o__dropping      (dropping),
        .o__count         (count),
        .o__drop_next     (drop_next)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, real-valued inverse square root.
    bit             m_vv = 0;
    bit             m_drop = 0;
    bit             m_dropping = 0;
    int             m_count = 0;
    int             m_last = 0;
    logic [T_W-1:0] m_dn = '0;

    function automatic logic [T_W-1:0] cl(input logic [T_W-1:0] base, input int c);
        int          n;
        longint      frac;
        logic [63:0] prod;
        n    = (c >= LUTD) ? LUTD : c;
        frac = longint'($rtoi(65535.0 / $sqrt(real'(n))));
        prod = 64'(interval) * 64'(frac);
        return base + prod[47:16];
    endfunction

    always @(posedge clk or negedge reset) begin
        int nc;
        if (!reset) begin
            m_vv = 0; m_drop = 0; m_dropping = 0; m_count = 0; m_last = 0; m_dn = '0;
        end else begin
            m_vv   = deq_valid;
            m_drop = 0;
            if (deq_valid) begin
                if (packet_null) begin
                    m_dropping = 0;
                end else if (!m_dropping) begin
                    if (okay_to_drop) begin
                        m_drop     = 1;
                        m_dropping = 1;
                        if (m_count > 2 && $signed(time_counter - m_dn) < $signed(interval * K))
                            nc = (m_count - m_last < 1) ? 1 : m_count - m_last;
                        else
                            nc = 1;
                        m_count = nc;
                        m_last  = nc;
                        m_dn    = cl(time_counter, nc);
                    end
                end else if (!okay_to_drop) begin
                    m_dropping = 0;
                end else if ($signed(time_counter - m_dn) >= 0) begin
                    m_drop  = 1;
                    m_count = (m_count >= 65535) ? 65535 : m_count + 1;
                    m_dn    = cl(m_dn, m_count);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [T_W-1:0] act, input logic [T_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.verdict_valid", 32'(verdict_valid), 32'(m_vv));
        if (m_vv) chk("m.drop", 32'(drop), 32'(m_drop));
        chk("m.dropping", 32'(dropping), 32'(m_dropping));
        chk("m.count", 32'(count), 32'(m_count));
        chk("m.drop_next", drop_next, m_dn);
    end

    // Called at a falling edge; returns at the next falling edge with the verdict visible.
    task automatic step(input logic v, input logic nul, input logic ok, input logic [T_W-1:0] t);
        deq_valid    = v;
        packet_null  = nul;
        okay_to_drop = ok;
        time_counter = t;
        @(negedge clk);
        deq_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst.vv", 32'(verdict_valid), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.drop_next", drop_next, 32'd0);

        // Entry and control law
        step(1, 0, 1, 32'd1000);
        chk("t2.drop", 32'(drop), 32'd1);
        chk("t2.dropping", 32'(dropping), 32'd1);
        chk("t2.count", 32'(count), 32'd1);
        chk("t2.drop_next", drop_next, 32'd1099);
        step(1, 0, 1, 32'd1050);
        chk("t3.early_drop", 32'(drop), 32'd0);
        step(1, 0, 1, 32'd1099);
        chk("t3.drop", 32'(drop), 32'd1);
        chk("t3.count", 32'(count), 32'd2);
        chk("t3.drop_next", drop_next, 32'd1169);

        // Exit, then re-entry with count not above 2
        step(1, 0, 0, 32'd1120);
        chk("t4.dropping", 32'(dropping), 32'd0);
        chk("t4.count_kept", 32'(count), 32'd2);
        step(1, 0, 1, 32'd1200);
        chk("t4.reenter_count", 32'(count), 32'd1);
        chk("t4.reenter_dn", drop_next, 32'd1299);
        step(0, 0, 0, 32'd1250);
        chk("idle.vv", 32'(verdict_valid), 32'd0);

        // Build count to 4, then re-enter inside the window
        step(1, 0, 1, 32'd1299);
        step(1, 0, 1, 32'd1369);
        step(1, 0, 1, 32'd1426);
        chk("re.count4", 32'(count), 32'd4);
        chk("re.dn4", drop_next, 32'd1475);
        step(1, 0, 0, 32'd1430);
        step(1, 0, 1, 32'd1500);
        chk("re.window_count", 32'(count), 32'd3);
        chk("re.window_dn", drop_next, 32'd1557);
        step(1, 0, 0, 32'd1510);
        step(1, 0, 1, 32'd1520);
        chk("re.floor_count", 32'(count), 32'd1);
        chk("re.floor_dn", drop_next, 32'd1619);
        step(1, 0, 1, 32'd1619);
        step(1, 0, 1, 32'd1689);
        step(1, 0, 0, 32'd1700);
        step(1, 0, 1, 32'd5000);
        chk("re.far_count", 32'(count), 32'd1);
        chk("re.far_dn", drop_next, 32'd5099);

        // Wrap-around due check
        step(1, 0, 0, 32'd5010);
        step(1, 0, 1, 32'hFFFF_FF8D);
        chk("t5.dn_pre", drop_next, 32'hFFFF_FFF0);
        step(1, 0, 1, 32'h0000_0010);
        chk("t5.drop", 32'(drop), 32'd1);
        chk("t5.dn", drop_next, 32'h0000_0036);

        // Empty dequeue, then idle cycle
        step(1, 1, 0, 32'h20);
        chk("t6.vv", 32'(verdict_valid), 32'd1);
        chk("t6.drop", 32'(drop), 32'd0);
        chk("t6.dropping", 32'(dropping), 32'd0);
        step(0, 0, 0, 32'h21);
        chk("t6.idle_vv", 32'(verdict_valid), 32'd0);

        // Back-to-back drops, past the end of the table
        step(1, 0, 1, 32'h100);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h20000);
        chk("bb.count5", 32'(count), 32'd5);
        for (int i = 0; i < 70; i++) step(1, 0, 1, 32'h20000);
        chk("bb.count75", 32'(count), 32'd75);

        // Asynchronous reset with a verdict in flight
        deq_valid    = 1'b1;
        okay_to_drop = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t1.vv", 32'(verdict_valid), 32'd0);
        chk("t1.dropping", 32'(dropping), 32'd0);
        chk("t1.count", 32'(count), 32'd0);
        chk("t1.drop_next", drop_next, 32'd0);
        deq_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
